// File: rtl/serial_adder_seq_if.sv
`default_nettype none
// ============================================================================
// serial_adder_seq_if : operand/result handshake bundle for serial_adder_seq
// Revision 1.0
// ============================================================================
interface serial_adder_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder_seq.sv
`default_nettype none
// ============================================================================
// serial_adder_seq : bit-serial adder, one full-adder cell reused WIDTH cycles
// Revision 1.0
// ============================================================================
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_seq_if.slave  bus
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic             w_s;
  logic             w_carry;
  logic [WIDTH-1:0] w_acc_shift;

  assign w_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign w_carry = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

  // The new sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_acc_single
      assign w_acc_shift = w_s;
    end else begin : g_acc_multi
      assign w_acc_shift = {w_s, acc_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = w_carry;
        acc_d   = w_acc_shift;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          sum_d   = w_acc_shift;
          cout_d  = w_carry;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_seq.sv
`default_nettype none
// ============================================================================
// tb_serial_adder_seq : directed checks of serial_adder_seq at WIDTH 8, 2, 1
// Revision 1.0
// ============================================================================
module tb_serial_adder_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_seq_if #(.WIDTH(8)) bus8 ();
  serial_adder_seq_if #(.WIDTH(2)) bus2 ();
  serial_adder_seq_if #(.WIDTH(1)) bus1 ();

  serial_adder_seq #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_adder_seq #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  serial_adder_seq #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns number of clock edges until done is seen.
  task automatic wait_done8(output int n);
    n = 0;
    while (n < 30 && bus8.done !== 1'b1) begin
      @(posedge clk); @(negedge clk); n++;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic [7:0] es, input logic ec, input string tag);
    int n;
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus8.start = 1'b0;
    chk({tag, "_busy"}, bus8.busy, 1);
    wait_done8(n);
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_sum"}, bus8.sum, es);
    chk({tag, "_cout"}, bus8.cout, ec);
    @(negedge clk);
    chk({tag, "_done_clr"}, bus8.done, 0);
    chk({tag, "_idle"}, bus8.busy, 0);
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic cin);
    int n;
    logic [2:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {2'b00, cin};
    @(negedge clk);
    bus2.a = a; bus2.b = b; bus2.cin = cin; bus2.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus2.start = 1'b0;
    n = 0;
    while (n < 10 && bus2.done !== 1'b1) begin
      @(posedge clk); @(negedge clk); n++;
    end
    chk($sformatf("w2_lat_%0d_%0d_%0d", a, b, cin), n, 2);
    chk($sformatf("w2_res_%0d_%0d_%0d", a, b, cin), {bus2.cout, bus2.sum}, exp);
  endtask

  task automatic run1(input logic a, input logic b, input logic cin);
    int n;
    logic [1:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {1'b0, cin};
    @(negedge clk);
    bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus1.start = 1'b0;
    n = 0;
    while (n < 10 && bus1.done !== 1'b1) begin
      @(posedge clk); @(negedge clk); n++;
    end
    chk($sformatf("w1_lat_%0d_%0d_%0d", a, b, cin), n, 1);
    chk($sformatf("w1_res_%0d_%0d_%0d", a, b, cin), {bus1.cout, bus1.sum}, exp);
  endtask

  initial begin
    int n;
    int pulses;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", bus8.busy, 0);
    chk("rst_done", bus8.done, 0);
    chk("rst_sum",  bus8.sum,  0);
    chk("rst_cout", bus8.cout, 0);
    chk("rst_w2",   {bus2.busy, bus2.done, bus2.cout, bus2.sum}, 0);
    chk("rst_w1",   {bus1.busy, bus1.done, bus1.cout, bus1.sum}, 0);

    // Basic add and carry chains
    run8(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, "basic");
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "carry_ff01");
    run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "carry_ffff1");
    run8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "cin_only");

    // Back-to-back with start held high
    @(negedge clk);
    bus8.a = 8'h01; bus8.b = 8'h02; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(posedge clk); @(negedge clk);
    wait_done8(n);
    chk("b2b_lat1", n, 8);
    chk("b2b_sum1", bus8.sum, 8'h03);
    chk("b2b_cout1", bus8.cout, 0);
    bus8.a = 8'h80; bus8.b = 8'h80;
    @(posedge clk); @(negedge clk);
    chk("b2b_accept_busy", bus8.busy, 1);
    chk("b2b_accept_done", bus8.done, 0);
    wait_done8(n);
    bus8.start = 1'b0;
    chk("b2b_lat2", n, 8);
    chk("b2b_sum2", bus8.sum, 8'h00);
    chk("b2b_cout2", bus8.cout, 1);
    @(negedge clk);
    chk("b2b_idle", bus8.busy, 0);

    // Start while busy is ignored
    @(negedge clk);
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) pulses++;
    end
    chk("busy_start_pulses", pulses, 1);
    chk("busy_start_sum", bus8.sum, 8'h30);
    chk("busy_start_cout", bus8.cout, 0);

    // Reset mid-operation
    @(negedge clk);
    bus8.a = 8'h7F; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", bus8.busy, 0);
    chk("midrst_done", bus8.done, 0);
    chk("midrst_sum",  bus8.sum,  0);
    chk("midrst_cout", bus8.cout, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    run8(8'h05, 8'h06, 1'b0, 8'h0B, 1'b0, "after_rst");

    // Exhaustive narrow widths
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          run2(2'(a), 2'(b), 1'(c));
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 2; c++)
          run1(1'(a), 1'(b), 1'(c));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
